// File: rtl/rv32_mem_pkg.sv
// Shared memory-side definitions: Func3 encodings, cache FSM states and block geometry.
package rv32_mem_pkg;

  localparam logic [2:0] FUNC3_B  = 3'b000;
  localparam logic [2:0] FUNC3_H  = 3'b001;
  localparam logic [2:0] FUNC3_W  = 3'b010;
  localparam logic [2:0] FUNC3_BU = 3'b100;
  localparam logic [2:0] FUNC3_HU = 3'b101;

  localparam int BLOCK_BITS  = 128;
  localparam int WORD_BITS   = 32;
  localparam int OFFSET_BITS = 4;
  localparam int BLKADDR_BITS = 32 - OFFSET_BITS;

  typedef enum logic [1:0] {
    CS_IDLE       = 2'd0,
    CS_WRITE_BACK = 2'd1,
    CS_ALLOCATE   = 2'd2
  } cache_state_e;

endpackage

// File: rtl/dcache_lane_ctrl.sv
// Byte/half extraction with sign or zero extension for loads, and byte-lane merge for stores.
module dcache_lane_ctrl
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] store_word_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word_i[{byte_off_i, 3'd0} +: 8];
  assign half_s = byte_off_i[1] ? word_i[31:16] : word_i[15:0];

  // Load extraction and extension
  always_comb begin
    load_data_o = word_i;
    case (func3_i)
      FUNC3_B:  load_data_o = {{24{byte_s[7]}}, byte_s};
      FUNC3_H:  load_data_o = {{16{half_s[15]}}, half_s};
      FUNC3_W:  load_data_o = word_i;
      FUNC3_BU: load_data_o = {24'd0, byte_s};
      FUNC3_HU: load_data_o = {16'd0, half_s};
      default:  load_data_o = word_i;
    endcase
  end

  // Store merge; unused low address bits are ignored for H and W
  always_comb begin
    store_word_o = word_i;
    case (func3_i)
      FUNC3_B: store_word_o[{byte_off_i, 3'd0} +: 8] = wdata_i[7:0];
      FUNC3_H: begin
        if (byte_off_i[1]) begin
          store_word_o[31:16] = wdata_i[15:0];
        end else begin
          store_word_o[15:0] = wdata_i[15:0];
        end
      end
      FUNC3_W: store_word_o = wdata_i;
      default: store_word_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a 128-bit block memory port.
module data_cache
  import rv32_mem_pkg::*;
#(
  parameter int INDEX_BITS = 3
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    Read,
  input  logic                    Write,
  input  logic [31:0]             Address,
  input  logic [31:0]             Write_data,
  input  logic [2:0]              Func3,
  output logic [31:0]             Read_data,
  output logic                    busywait,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [BLKADDR_BITS-1:0] mem_address,
  output logic [BLOCK_BITS-1:0]   mem_writedata,
  input  logic [BLOCK_BITS-1:0]   mem_readdata,
  input  logic                    mem_busywait
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = BLKADDR_BITS - INDEX_BITS;

  cache_state_e state_q, state_d;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [LINES-1:0]      dirty_q, dirty_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [BLOCK_BITS-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] index_s;
  logic [TAG_W-1:0]      tag_s;
  logic [1:0]            word_s;
  logic                  req_s;
  logic                  hit_s;
  logic [BLOCK_BITS-1:0] cur_line_s;
  logic [31:0]           cur_word_s;
  logic [31:0]           load_word_s;
  logic [31:0]           store_word_s;
  logic                  line_we_s;
  logic [BLOCK_BITS-1:0] line_d;

  assign index_s    = Address[INDEX_BITS+3:4];
  assign tag_s      = Address[31:INDEX_BITS+4];
  assign word_s     = Address[3:2];
  assign req_s      = Read | Write;
  assign hit_s      = valid_q[index_s] && (tag_q[index_s] == tag_s);
  assign cur_line_s = data_q[index_s];
  assign cur_word_s = cur_line_s[{word_s, 5'd0} +: 32];

  dcache_lane_ctrl u_lane_ctrl (
    .func3_i      (Func3),
    .byte_off_i   (Address[1:0]),
    .word_i       (cur_word_s),
    .wdata_i      (Write_data),
    .load_data_o  (load_word_s),
    .store_word_o (store_word_s)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= CS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      CS_IDLE: begin
        if (req_s && !hit_s) begin
          if (valid_q[index_s] && dirty_q[index_s]) begin
            state_d = CS_WRITE_BACK;
          end else begin
            state_d = CS_ALLOCATE;
          end
        end else begin
          state_d = CS_IDLE;
        end
      end
      CS_WRITE_BACK: state_d = mem_busywait ? CS_WRITE_BACK : CS_ALLOCATE;
      CS_ALLOCATE:   state_d = mem_busywait ? CS_ALLOCATE : CS_IDLE;
      default:       state_d = CS_IDLE;
    endcase
  end

  // FSM outputs toward the pipeline and memory
  always_comb begin
    Read_data     = 32'd0;
    busywait      = (state_q != CS_IDLE) || (req_s && !hit_s);
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      CS_IDLE: begin
        if (Read && !Write && hit_s) begin
          Read_data = load_word_s;
        end else begin
          Read_data = 32'd0;
        end
      end
      CS_WRITE_BACK: begin
        mem_write     = 1'b1;
        mem_address   = {tag_q[index_s], index_s};
        mem_writedata = cur_line_s;
      end
      CS_ALLOCATE: begin
        mem_read    = 1'b1;
        mem_address = Address[31:4];
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  // Line fill on allocate completion, word merge on store hit
  always_comb begin
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    line_we_s = 1'b0;
    line_d    = cur_line_s;
    if (state_q == CS_ALLOCATE && !mem_busywait) begin
      line_we_s        = 1'b1;
      line_d           = mem_readdata;
      valid_d[index_s] = 1'b1;
      dirty_d[index_s] = 1'b0;
    end else if (state_q == CS_IDLE && Write && hit_s) begin
      line_we_s                       = 1'b1;
      line_d[{word_s, 5'd0} +: 32]    = store_word_s;
      dirty_d[index_s]                = 1'b1;
    end else begin
      line_we_s = 1'b0;
    end
  end

  // Valid and dirty bits; reset invalidates every line and drops dirty data
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays are not cleared by reset
  always_ff @(posedge CLK) begin
    if (!RESET && line_we_s) begin
      data_q[index_s] <= line_d;
      if (state_q == CS_ALLOCATE) begin
        tag_q[index_s] <= tag_s;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed table-driven bench for data_cache with a fixed-latency block memory model.
module tb_data_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         Read = 1'b0;
  logic         Write = 1'b0;
  logic [31:0]  Address = 32'd0;
  logic [31:0]  Write_data = 32'd0;
  logic [2:0]   Func3 = 3'b010;
  logic [31:0]  Read_data;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  localparam int LAT = 3;

  logic [127:0] mem [256];
  logic         preload = 1'b1;
  int           busy_cnt = 0;
  logic [27:0]  last_wb_addr = 28'd0;
  logic [127:0] last_wb_data = 128'd0;
  logic [27:0]  last_rd_addr = 28'd0;
  int           both_seen = 0;

  int n_cmp = 0;
  int n_err = 0;

  data_cache #(.INDEX_BITS(3)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .Read          (Read),
    .Write         (Write),
    .Address       (Address),
    .Write_data    (Write_data),
    .Func3         (Func3),
    .Read_data     (Read_data),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  assign mem_busywait = (mem_read || mem_write) && (busy_cnt < LAT);
  assign mem_readdata = mem[mem_address[7:0]];

  // Memory model: busy for LAT cycles per request, completes on the following edge
  always @(posedge CLK) begin
    if (mem_read && mem_write) both_seen <= both_seen + 1;
    if ((mem_read || mem_write) && mem_busywait) busy_cnt <= busy_cnt + 1;
    else busy_cnt <= 0;
    if (preload) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= {32'(i) + 32'h3000, 32'(i) + 32'h2000, 32'(i) + 32'h1000, 32'(i)};
      mem[1]  <= {32'h3001, 32'h2001, 32'h1001, 32'hDEADBEEF};
      mem[9]  <= {32'h3009, 32'h2009, 32'h1009, 32'hCAFEF00D};
      mem[2]  <= {32'h3002, 32'h2002, 32'h11112222, 32'h00000002};
      mem[10] <= {32'h300A, 32'h200A, 32'h100A, 32'h0BADC0DE};
    end else if (mem_write && !mem_busywait) begin
      mem[mem_address[7:0]] <= mem_writedata;
      last_wb_addr <= mem_address;
      last_wb_data <= mem_writedata;
    end else if (mem_read && !mem_busywait) begin
      last_rd_addr <= mem_address;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  vec_t vecs [15];

  // Drive a request at a negedge, count stall cycles, compare load data in the hit cycle
  task automatic do_req(input vec_t v, input int idx);
    int stalls;
    Read = v.rd; Write = v.wr; Func3 = v.f3; Address = v.addr; Write_data = v.wdata;
    stalls = 0;
    #1;
    while (busywait && stalls < 200) begin
      @(negedge CLK);
      stalls++;
    end
    check($sformatf("v%0d_stalls", idx), 128'(stalls), 128'(v.exp_stall));
    check($sformatf("v%0d_rdata", idx), 128'(Read_data), 128'(v.exp_data));
    @(negedge CLK);
    Read = 1'b0; Write = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 5};
    vecs[1]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h10, 32'h0,        32'h0000BEEF, 0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h11, 32'h55,       32'h00000000, 0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h90, 32'h0,        32'hCAFEF00D, 9};
    vecs[9]  = '{1'b1, 1'b0, 3'b010, 32'h94, 32'h0,        32'h00001009, 0};
    vecs[10] = '{1'b0, 1'b1, 3'b010, 32'h20, 32'h12345678, 32'h00000000, 5};
    vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0,        32'h12345678, 0};
    vecs[12] = '{1'b0, 1'b1, 3'b001, 32'h26, 32'hFFFFABCD, 32'h00000000, 0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h24, 32'h0,        32'hABCD2222, 0};
    vecs[14] = '{1'b1, 1'b0, 3'b010, 32'hA0, 32'h0,        32'h0BADC0DE, 9};

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    preload = 1'b0;
    #1;
    check("rst_busywait", 128'(busywait), 128'd0);
    check("rst_mem_read", 128'(mem_read), 128'd0);
    check("rst_mem_write", 128'(mem_write), 128'd0);
    check("rst_mem_address", 128'(mem_address), 128'd0);
    check("rst_mem_writedata", mem_writedata, 128'd0);
    check("rst_read_data", 128'(Read_data), 128'd0);
    @(negedge CLK);

    // First miss: observe the allocate request cycle by cycle
    Read = 1'b1; Func3 = 3'b010; Address = 32'h10;
    #1;
    check("miss_busy_idle", 128'(busywait), 128'd1);
    check("miss_no_memreq", 128'(mem_read | mem_write), 128'd0);
    @(negedge CLK);
    check("alloc_mem_read", 128'(mem_read), 128'd1);
    check("alloc_mem_address", 128'(mem_address), 128'h0000001);
    Read = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    check("alloc_done_mem_read", 128'(mem_read), 128'd0);
    check("alloc_done_rd_addr", 128'(last_rd_addr), 128'h0000001);

    for (int i = 1; i < 15; i++) begin
      do_req(vecs[i], i);
      if (i == 8) begin
        check("wb_addr_0x10", 128'(last_wb_addr), 128'h0000001);
        check("wb_data_0x10", 128'(last_wb_data[31:0]), 128'hDEAD55EF);
        check("alloc_addr_0x90", 128'(last_rd_addr), 128'h0000009);
      end
      if (i == 14) begin
        check("wb_addr_0x20", 128'(last_wb_addr), 128'h0000002);
        check("wb_data_0x20_w0", 128'(last_wb_data[31:0]), 128'h12345678);
        check("wb_data_0x20_w1", 128'(last_wb_data[63:32]), 128'hABCD2222);
      end
    end
    check("never_rd_and_wr", 128'(both_seen), 128'd0);

    // Reset in the middle of an allocate
    Read = 1'b1; Func3 = 3'b010; Address = 32'h30;
    @(negedge CLK);
    @(negedge CLK);
    check("pre_rst_mem_read", 128'(mem_read), 128'd1);
    RESET = 1'b1; Read = 1'b0;
    @(negedge CLK);
    check("rst_mid_mem_read", 128'(mem_read), 128'd0);
    check("rst_mid_busywait", 128'(busywait), 128'd0);
    RESET = 1'b0;
    do_req('{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 5}, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
